pll_lock_sequencer: RTL and testbench

- Sits directly downstream of the cycloneV PLL wrapper and runs on the PLL reference clock.
- Drives the PLL reset pulse, waits for `locked`, and requires lock to stay stable before releasing the system reset to logic on the PLL output clocks.
- Re-sequences the PLL on lock loss or lock timeout, retries a bounded number of times, then enters a sticky fault.

---
 rtl/pll_seq_pkg.sv | 31 +++
 rtl/sync_2ff.sv | 25 ++
 rtl/pll_lock_sequencer.sv | 144 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      PLL_RESET = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_t;

   localparam int DEF_RST_PULSE_CYCLES    = 16;
   localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 500000;

   // One shared counter must reach the largest terminal value minus one.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      else       m = m;
      if (c > m) m = c;
      else       m = m;
      if ($clog2(m) < 1) return 1;
      else               return $clog2(m);
   endfunction

   localparam int CNT_W = cnt_width(DEF_RST_PULSE_CYCLES, DEF_LOCK_STABLE_CYCLES,
                                    DEF_LOCK_TIMEOUT_CYCLES);

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, async active-high reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic sync_r;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, lock qualification and downstream reset release,
// with bounded retries and a sticky fault.
module pll_lock_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int MAX_RETRIES         = 3,
   parameter int RETRY_W             = 2
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               pll_locked,
   input  logic               force_reset,
   output logic               pll_rst,
   output logic               sys_rst,
   output logic               ready,
   output logic               lock_lost,
   output logic [RETRY_W-1:0] retry_count,
   output logic               fault
);

   localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
   localparam logic [CW-1:0]      RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
   localparam logic [CW-1:0]      STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0]      TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

   state_t             state_r, state_nxt_s;
   logic [CW-1:0]      cnt_r, cnt_nxt_s;
   logic [RETRY_W-1:0] retry_r, retry_nxt_s;
   logic               lock_lost_nxt_s;
   logic               locked_s;
   logic               pll_rst_r, sys_rst_r, ready_r, lock_lost_r, fault_r;

   sync_2ff u_sync_locked (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (locked_s)
   );

   // Next-state, counter and retry decisions in priority order.
   always_comb begin
      state_nxt_s     = state_r;
      cnt_nxt_s       = cnt_r + CW'(1);
      retry_nxt_s     = retry_r;
      lock_lost_nxt_s = 1'b0;
      if (force_reset) begin
         state_nxt_s = PLL_RESET;
         cnt_nxt_s   = '0;
         retry_nxt_s = '0;
      end else begin
         case (state_r)
            PLL_RESET: begin
               if (cnt_r == RST_LAST) begin
                  state_nxt_s = WAIT_LOCK;
                  cnt_nxt_s   = '0;
               end else begin
                  state_nxt_s = PLL_RESET;
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state_nxt_s = STABILIZE;
                  cnt_nxt_s   = '0;
               end else if (cnt_r == TIMEOUT_LAST) begin
                  cnt_nxt_s = '0;
                  if (retry_r == RETRY_MAX) begin
                     state_nxt_s = FAULT;
                  end else begin
                     state_nxt_s = PLL_RESET;
                     retry_nxt_s = retry_r + RETRY_W'(1);
                  end
               end else begin
                  state_nxt_s = WAIT_LOCK;
               end
            end
            STABILIZE: begin
               if (!locked_s) begin
                  state_nxt_s = WAIT_LOCK;
                  cnt_nxt_s   = '0;
               end else if (cnt_r == STABLE_LAST) begin
                  state_nxt_s = RUN;
                  cnt_nxt_s   = '0;
                  retry_nxt_s = '0;
               end else begin
                  state_nxt_s = STABILIZE;
               end
            end
            RUN: begin
               cnt_nxt_s = '0;
               if (!locked_s) begin
                  state_nxt_s     = PLL_RESET;
                  lock_lost_nxt_s = 1'b1;
               end else begin
                  state_nxt_s = RUN;
               end
            end
            FAULT: begin
               state_nxt_s = FAULT;
               cnt_nxt_s   = '0;
            end
            default: begin
               state_nxt_s = PLL_RESET;
               cnt_nxt_s   = '0;
               retry_nxt_s = '0;
            end
         endcase
      end
   end

   // State, counter and Moore outputs decoded from the next state on the same edge.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_r     <= PLL_RESET;
         cnt_r       <= '0;
         retry_r     <= '0;
         pll_rst_r   <= 1'b1;
         sys_rst_r   <= 1'b1;
         ready_r     <= 1'b0;
         lock_lost_r <= 1'b0;
         fault_r     <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         retry_r     <= retry_nxt_s;
         pll_rst_r   <= (state_nxt_s == PLL_RESET) || (state_nxt_s == FAULT);
         sys_rst_r   <= (state_nxt_s != RUN);
         ready_r     <= (state_nxt_s == RUN);
         lock_lost_r <= lock_lost_nxt_s;
         fault_r     <= (state_nxt_s == FAULT);
      end
   end

   assign pll_rst     = pll_rst_r;
   assign sys_rst     = sys_rst_r;
   assign ready       = ready_r;
   assign lock_lost   = lock_lost_r;
   assign retry_count = retry_r;
   assign fault       = fault_r;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed, table-driven bench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;

   logic       refclk = 1'b0;
   logic       rst;
   logic       pll_locked;
   logic       force_reset;
   logic       pll_rst, sys_rst, ready, lock_lost, fault;
   logic [1:0] retry_count;

   int errors = 0;
   int checks = 0;

   // exp packs {pll_rst, sys_rst, ready, lock_lost, fault, retry_count[1:0]}
   typedef struct {
      int         n;
      logic       lk;
      logic       frc;
      logic       hold;
      logic [6:0] exp;
   } vec_t;

   vec_t vq[$];

   pll_lock_sequencer #(
      .RST_PULSE_CYCLES    (4),
      .LOCK_STABLE_CYCLES  (8),
      .LOCK_TIMEOUT_CYCLES (20),
      .MAX_RETRIES         (2),
      .RETRY_W             (2)
   ) dut (
      .refclk      (refclk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .force_reset (force_reset),
      .pll_rst     (pll_rst),
      .sys_rst     (sys_rst),
      .ready       (ready),
      .lock_lost   (lock_lost),
      .retry_count (retry_count),
      .fault       (fault)
   );

   always #5 refclk = ~refclk;

   task automatic step();
      @(posedge refclk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [6:0] exp);
      logic [6:0] got;
      got = {pll_rst, sys_rst, ready, lock_lost, fault, retry_count};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got={rst,sys,rdy,ll,flt,rc}=%b expected=%b at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic add(input int n, input logic lk, input logic frc, input logic hold,
                      input logic [6:0] exp);
      vec_t v;
      v.n = n; v.lk = lk; v.frc = frc; v.hold = hold; v.exp = exp;
      vq.push_back(v);
   endtask

   initial begin
      // Edge numbers in comments count from the first edge after rst release.
      // normal bring-up
      add(3,   1'b0, 1'b0, 1'b0, 7'b1100000); // e3  pll_rst still high
      add(1,   1'b0, 1'b0, 1'b0, 7'b0100000); // e4  pulse ends
      add(5,   1'b0, 1'b0, 1'b0, 7'b0100000); // e9
      add(10,  1'b1, 1'b0, 1'b0, 7'b0100000); // e19 one short of release
      add(1,   1'b1, 1'b0, 1'b0, 7'b0010000); // e20 RUN
      // lock loss in RUN
      add(5,   1'b1, 1'b0, 1'b1, 7'b0010000); // e21-25
      add(2,   1'b0, 1'b0, 1'b0, 7'b0010000); // e27 sync latency
      add(1,   1'b0, 1'b0, 1'b0, 7'b1101000); // e28 lock_lost pulse
      add(1,   1'b0, 1'b0, 1'b0, 7'b1100000); // e29 pulse gone
      add(2,   1'b0, 1'b0, 1'b0, 7'b1100000); // e31
      add(1,   1'b0, 1'b0, 1'b0, 7'b0100000); // e32 WAIT_LOCK
      add(10,  1'b1, 1'b0, 1'b0, 7'b0100000); // e42
      add(1,   1'b1, 1'b0, 1'b0, 7'b0010000); // e43 RUN again
      // force restart, then glitch during STABILIZE at the terminal count
      add(1,   1'b1, 1'b1, 1'b0, 7'b1100000); // e44
      add(10,  1'b1, 1'b0, 1'b0, 7'b0100000); // e54 STABILIZE
      add(3,   1'b0, 1'b0, 1'b1, 7'b0100000); // e55-57 glitch, no RUN
      add(10,  1'b1, 1'b0, 1'b1, 7'b0100000); // e58-67 full restart of count
      add(1,   1'b1, 1'b0, 1'b0, 7'b0010000); // e68
      // retries exhausted
      add(1,   1'b0, 1'b1, 1'b0, 7'b1100000); // e69
      add(4,   1'b0, 1'b0, 1'b0, 7'b0100000); // e73
      add(19,  1'b0, 1'b0, 1'b0, 7'b0100000); // e92
      add(1,   1'b0, 1'b0, 1'b0, 7'b1100001); // e93 retry 1
      add(4,   1'b0, 1'b0, 1'b0, 7'b0100001); // e97
      add(20,  1'b0, 1'b0, 1'b0, 7'b1100010); // e117 retry 2
      add(23,  1'b0, 1'b0, 1'b0, 7'b0100010); // e140
      add(1,   1'b0, 1'b0, 1'b0, 7'b1100110); // e141 FAULT
      add(200, 1'b0, 1'b0, 1'b1, 7'b1100110); // sticky
      // recovery from FAULT
      add(1,   1'b1, 1'b1, 1'b0, 7'b1100000); // e342
      add(3,   1'b1, 1'b0, 1'b0, 7'b1100000); // e345
      add(1,   1'b1, 1'b0, 1'b0, 7'b0100000); // e346
      add(8,   1'b1, 1'b0, 1'b0, 7'b0100000); // e354
      add(1,   1'b1, 1'b0, 1'b0, 7'b0010000); // e355
      // force_reset held keeps the pulse counter at zero
      add(10,  1'b1, 1'b1, 1'b1, 7'b1100000); // e356-365
      add(3,   1'b1, 1'b0, 1'b0, 7'b1100000); // e368
      add(1,   1'b1, 1'b0, 1'b0, 7'b0100000); // e369
      add(8,   1'b1, 1'b0, 1'b0, 7'b0100000); // e377
      add(1,   1'b1, 1'b0, 1'b0, 7'b0010000); // e378

      rst = 1'b1; pll_locked = 1'b0; force_reset = 1'b0;
      step();
      chk("reset_a", 7'b1100000);
      step();
      chk("reset_b", 7'b1100000);
      rst = 1'b0;

      foreach (vq[i]) begin
         pll_locked  = vq[i].lk;
         force_reset = vq[i].frc;
         for (int c = 0; c < vq[i].n; c++) begin
            step();
            if (vq[i].hold && (c != vq[i].n - 1)) chk($sformatf("vec%0d_c%0d", i, c), vq[i].exp);
         end
         chk($sformatf("vec%0d", i), vq[i].exp);
      end

      // async reset between edges while in STABILIZE
      force_reset = 1'b1;
      step();
      force_reset = 1'b0;
      repeat (5) step();
      repeat (3) step();
      chk("pre_async", 7'b0100000);
      #2 rst = 1'b1;
      #1 chk("async_rst", 7'b1100000);
      step();
      chk("rst_held", 7'b1100000);
      rst = 1'b0;
      repeat (3) step();
      chk("restart_pulse", 7'b1100000);
      step();
      chk("restart_wait", 7'b0100000);
      repeat (8) step();
      chk("restart_stab", 7'b0100000);
      step();
      chk("restart_run", 7'b0010000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
